// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : 6502 fetch unit. Loads the reset vector, fetches opcode plus
//            operands, and presents them to the decoder until it is done.
// Revision : 1.0  initial release
// ============================================================================

module instr_fetch #(
    parameter int                    REG_WIDTH    = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_valid,
    output logic [REG_WIDTH-1:0]  instruction_out,
    output logic [ADDR_WIDTH-1:0] operand_addr,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    output logic [ADDR_WIDTH-1:0] pc
);

    typedef enum logic [2:0] {
        ST_VEC_LO = 3'd0,
        ST_VEC_HI = 3'd1,
        ST_OP     = 3'd2,
        ST_OPR_LO = 3'd3,
        ST_OPR_HI = 3'd4,
        ST_ISSUE  = 3'd5,
        ST_WAIT   = 3'd6,
        ST_GAP    = 3'd7
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_vec_hi = RESET_VECTOR + ADDR_WIDTH'(1);

    state_t                  r_state,    w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc,       w_pc_nxt;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic                    r_mem_rd,   w_mem_rd_nxt;
    logic [REG_WIDTH-1:0]    r_instr,    w_instr_nxt;
    logic [ADDR_WIDTH-1:0]   r_operand,  w_operand_nxt;
    logic                    r_ready,    w_ready_nxt;
    logic [1:0]              r_len,      w_len_nxt;
    logic [REG_WIDTH-1:0]    r_lo,       w_lo_nxt;
    logic [REG_WIDTH-1:0]    r_hi,       w_hi_nxt;

    logic [1:0]              w_len_op;
    logic [ADDR_WIDTH-1:0]   w_pc_inc;

    // Operand byte count from the 6502 aaabbbcc opcode layout.
    function automatic logic [1:0] f_len(input logic [REG_WIDTH-1:0] op);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [1:0] len;
        cc  = op[1:0];
        bbb = op[4:2];
        len = 2'd0;
        case (cc)
            2'b01: begin
                if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111)
                    len = 2'd2;
                else
                    len = 2'd1;
            end
            2'b11: len = 2'd0;
            default: begin
                case (bbb)
                    3'b001, 3'b101: len = 2'd1;
                    3'b011, 3'b111: len = 2'd2;
                    3'b010, 3'b110: len = 2'd0;
                    3'b000: begin
                        if (cc == 2'b10)
                            len = 2'd1;
                        else if (op[7:0] == 8'h20)
                            len = 2'd2;
                        else if (op[7:0] == 8'h00 || op[7:0] == 8'h40 || op[7:0] == 8'h60)
                            len = 2'd0;
                        else
                            len = 2'd1;
                    end
                    3'b100:  len = (cc == 2'b00) ? 2'd1 : 2'd0;
                    default: len = 2'd0;
                endcase
            end
        endcase
        return len;
    endfunction

    assign w_len_op = f_len(mem_rdata);
    assign w_pc_inc = r_pc + ADDR_WIDTH'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rd_nxt   = r_mem_rd;
        w_instr_nxt    = r_instr;
        w_operand_nxt  = r_operand;
        w_ready_nxt    = r_ready;
        w_len_nxt      = r_len;
        w_lo_nxt       = r_lo;
        w_hi_nxt       = r_hi;

        case (r_state)
            ST_VEC_LO: begin
                if (!r_mem_rd) begin
                    w_mem_rd_nxt   = 1'b1;
                    w_mem_addr_nxt = RESET_VECTOR;
                end else if (mem_valid) begin
                    w_lo_nxt       = mem_rdata;
                    w_mem_addr_nxt = c_vec_hi;
                    w_state_nxt    = ST_VEC_HI;
                end
            end

            ST_VEC_HI: begin
                if (mem_valid) begin
                    w_pc_nxt       = {mem_rdata, r_lo};
                    w_mem_addr_nxt = {mem_rdata, r_lo};
                    w_state_nxt    = ST_OP;
                end
            end

            ST_OP, ST_OPR_LO, ST_OPR_HI, ST_ISSUE: begin
                // A redirect drops the fetch in progress; a late mem_valid is never looked at.
                if (pc_load) begin
                    w_mem_rd_nxt = 1'b0;
                    w_pc_nxt     = pc_load_value;
                    w_state_nxt  = ST_GAP;
                end else if (r_state == ST_ISSUE) begin
                    case (r_len)
                        2'd1:    w_operand_nxt = {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, r_lo};
                        2'd2:    w_operand_nxt = {r_hi, r_lo};
                        default: w_operand_nxt = '0;
                    endcase
                    w_ready_nxt = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else if (mem_valid) begin
                    w_pc_nxt       = w_pc_inc;
                    w_mem_addr_nxt = w_pc_inc;
                    if (r_state == ST_OP) begin
                        w_instr_nxt = mem_rdata;
                        w_len_nxt   = w_len_op;
                        if (w_len_op != 2'd0) begin
                            w_state_nxt = ST_OPR_LO;
                        end else begin
                            w_mem_rd_nxt = 1'b0;
                            w_state_nxt  = ST_ISSUE;
                        end
                    end else if (r_state == ST_OPR_LO) begin
                        w_lo_nxt = mem_rdata;
                        if (r_len == 2'd2) begin
                            w_state_nxt = ST_OPR_HI;
                        end else begin
                            w_mem_rd_nxt = 1'b0;
                            w_state_nxt  = ST_ISSUE;
                        end
                    end else begin
                        w_hi_nxt     = mem_rdata;
                        w_mem_rd_nxt = 1'b0;
                        w_state_nxt  = ST_ISSUE;
                    end
                end
            end

            ST_WAIT: begin
                if (pc_load)
                    w_pc_nxt = pc_load_value;
                if (instruction_done) begin
                    w_ready_nxt = 1'b0;
                    w_state_nxt = ST_GAP;
                end
            end

            // One idle cycle with ready low so the decoder sees a fresh rising edge.
            ST_GAP: begin
                w_mem_rd_nxt   = 1'b1;
                w_mem_addr_nxt = pc_load ? pc_load_value : r_pc;
                if (pc_load)
                    w_pc_nxt = pc_load_value;
                w_state_nxt = ST_OP;
            end

            default: w_state_nxt = ST_VEC_LO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_VEC_LO;
            r_pc       <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_instr    <= '0;
            r_operand  <= '0;
            r_ready    <= 1'b0;
            r_len      <= 2'd0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_instr    <= w_instr_nxt;
            r_operand  <= w_operand_nxt;
            r_ready    <= w_ready_nxt;
            r_len      <= w_len_nxt;
            r_lo       <= w_lo_nxt;
            r_hi       <= w_hi_nxt;
        end
    end

    assign mem_addr          = r_mem_addr;
    assign mem_rd            = r_mem_rd;
    assign instruction_out   = r_instr;
    assign operand_addr      = r_operand;
    assign instruction_ready = r_ready;
    assign pc                = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed vector bench for instr_fetch with a small memory model.
// Revision : 1.0  initial release
// ============================================================================

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic [7:0]  instruction_out;
    logic [15:0] operand_addr;
    logic        instruction_ready;
    logic        instruction_done;
    logic [15:0] pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .REG_WIDTH    (8),
        .ADDR_WIDTH   (16),
        .RESET_VECTOR (16'hFFFC)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc_load           (pc_load),
        .pc_load_value     (pc_load_value),
        .mem_addr          (mem_addr),
        .mem_rd            (mem_rd),
        .mem_rdata         (mem_rdata),
        .mem_valid         (mem_valid),
        .instruction_out   (instruction_out),
        .operand_addr      (operand_addr),
        .instruction_ready (instruction_ready),
        .instruction_done  (instruction_done),
        .pc                (pc)
    );

    // Memory model: zero-wait except for delay_addr, which answers after delay_n wait cycles.
    logic [7:0]  mem [0:65535];
    logic [15:0] delay_addr = 16'h0000;
    int          delay_n    = 0;
    int          wait_cnt;
    int          rd_count;

    always_comb begin
        mem_valid = mem_rd && ((mem_addr != delay_addr) || (wait_cnt >= delay_n));
        mem_rdata = mem_valid ? mem[mem_addr] : 8'h00;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 0;
            rd_count <= 0;
        end else begin
            if (mem_rd && !mem_valid) wait_cnt <= wait_cnt + 1;
            else                      wait_cnt <= 0;
            if (mem_rd && mem_valid)  rd_count <= rd_count + 1;
        end
    end

    typedef struct {
        logic [15:0] start;
        logic [7:0]  b0, b1, b2;
        logic [1:0]  len;
        logic [15:0] exp_opnd;
        logic [15:0] exp_pc;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_rd"},   mem_rd,            0);
        chk({tag, "_mem_addr"}, mem_addr,          0);
        chk({tag, "_instr"},    instruction_out,   0);
        chk({tag, "_operand"},  operand_addr,      0);
        chk({tag, "_ready"},    instruction_ready, 0);
        chk({tag, "_pc"},       pc,                0);
    endtask

    task automatic do_reset(input logic [15:0] vec, input bit check_vals);
        mem[16'hFFFC] = vec[7:0];
        mem[16'hFFFD] = vec[15:8];
        @(negedge clk);
        reset_n          = 1'b0;
        pc_load          = 1'b0;
        instruction_done = 1'b0;
        #1;
        if (check_vals) chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_to_ready(input logic [15:0] opaddr, output int lat, output bit ok);
        int op_cyc;
        op_cyc = -1;
        ok     = 1'b0;
        lat    = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (op_cyc < 0 && mem_rd && mem_valid && mem_addr == opaddr) op_cyc = i;
            if (instruction_ready) begin
                ok  = 1'b1;
                lat = (op_cyc < 0) ? -1 : i - op_cyc;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instruction_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_read(input logic [15:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        bit          ok;
        bit          saw_ready;
        logic [15:0] a;

        reset_n          = 1'b0;
        pc_load          = 1'b0;
        pc_load_value    = 16'h0000;
        instruction_done = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;

        // start, b0, b1, b2, len, operand, pc after fetch
        vecs[0]  = '{16'h8000, 8'hA9, 8'h42, 8'h77, 2'd1, 16'h0042, 16'h8002};
        vecs[1]  = '{16'h8000, 8'h8D, 8'h34, 8'h12, 2'd2, 16'h1234, 16'h8003};
        vecs[2]  = '{16'h8000, 8'hE8, 8'h55, 8'h66, 2'd0, 16'h0000, 16'h8001};
        vecs[3]  = '{16'h8000, 8'h20, 8'hCD, 8'hAB, 2'd2, 16'hABCD, 16'h8003};
        vecs[4]  = '{16'h8000, 8'h00, 8'h11, 8'h22, 2'd0, 16'h0000, 16'h8001};
        vecs[5]  = '{16'h8000, 8'hD0, 8'h05, 8'h99, 2'd1, 16'h0005, 16'h8002};
        vecs[6]  = '{16'h8000, 8'h0A, 8'h33, 8'h44, 2'd0, 16'h0000, 16'h8001};
        vecs[7]  = '{16'h8000, 8'hBD, 8'h00, 8'h20, 2'd2, 16'h2000, 16'h8003};
        vecs[8]  = '{16'h8000, 8'hA2, 8'h10, 8'h88, 2'd1, 16'h0010, 16'h8002};
        vecs[9]  = '{16'h8000, 8'h9A, 8'h12, 8'h34, 2'd0, 16'h0000, 16'h8001};
        vecs[10] = '{16'h8000, 8'hB1, 8'h80, 8'hAA, 2'd1, 16'h0080, 16'h8002};
        vecs[11] = '{16'h8000, 8'hFF, 8'h12, 8'h34, 2'd0, 16'h0000, 16'h8001};
        vecs[12] = '{16'hFFFF, 8'hAD, 8'h78, 8'h56, 2'd2, 16'h5678, 16'h0002};
        vecs[13] = '{16'h1234, 8'h4C, 8'h00, 8'hC0, 2'd2, 16'hC000, 16'h1237};
        vecs[14] = '{16'h4000, 8'h60, 8'h01, 8'h02, 2'd0, 16'h0000, 16'h4001};
        vecs[15] = '{16'h4000, 8'h96, 8'h44, 8'hBB, 2'd1, 16'h0044, 16'h4002};
        vecs[16] = '{16'h4000, 8'h10, 8'hFE, 8'hCC, 2'd1, 16'h00FE, 16'h4002};
        vecs[17] = '{16'h4000, 8'h18, 8'h01, 8'h02, 2'd0, 16'h0000, 16'h4001};

        for (int v = 0; v < NV; v++) begin
            a = vecs[v].start;
            mem[a] = vecs[v].b0;
            a = a + 16'd1;
            mem[a] = vecs[v].b1;
            a = a + 16'd1;
            mem[a] = vecs[v].b2;
            do_reset(vecs[v].start, v == 0);
            run_to_ready(vecs[v].start, lat, ok);
            chk($sformatf("v%0d_ready_seen", v), ok, 1);
            chk($sformatf("v%0d_latency", v), lat, 2 + vecs[v].len);
            chk($sformatf("v%0d_instr", v), instruction_out, vecs[v].b0);
            chk($sformatf("v%0d_operand", v), operand_addr, vecs[v].exp_opnd);
            chk($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
            chk($sformatf("v%0d_reads", v), rd_count, 3 + vecs[v].len);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_hold_ready", v), instruction_ready, 1);
            chk($sformatf("v%0d_hold_instr", v), instruction_out, vecs[v].b0);
            chk($sformatf("v%0d_hold_operand", v), operand_addr, vecs[v].exp_opnd);
            chk($sformatf("v%0d_hold_no_rd", v), mem_rd, 0);
            instruction_done = 1'b1;
            @(negedge clk);
            instruction_done = 1'b0;
            chk($sformatf("v%0d_gap_ready", v), instruction_ready, 0);
            chk($sformatf("v%0d_gap_rd", v), mem_rd, 0);
            @(negedge clk);
            chk($sformatf("v%0d_next_rd", v), mem_rd, 1);
            chk($sformatf("v%0d_next_addr", v), mem_addr, vecs[v].exp_pc);
        end

        // Operand read stalled three cycles: address and request must hold, one capture only.
        mem[16'h8000] = 8'h8D;
        mem[16'h8001] = 8'h34;
        mem[16'h8002] = 8'h12;
        delay_addr = 16'h8001;
        delay_n    = 3;
        do_reset(16'h8000, 0);
        wait_read(16'h8001, ok);
        chk("dly_read_seen", ok, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dly_hold%0d", k), {mem_rd, mem_valid, mem_addr}, {1'b1, 1'b0, 16'h8001});
            @(negedge clk);
        end
        chk("dly_valid", {mem_rd, mem_valid, mem_addr}, {1'b1, 1'b1, 16'h8001});
        wait_ready(ok);
        chk("dly_ready_seen", ok, 1);
        chk("dly_operand", operand_addr, 16'h1234);
        chk("dly_reads", rd_count, 5);
        chk("dly_pc", pc, 16'h8003);

        // Redirect while the high operand byte is outstanding.
        mem[16'hC000] = 8'hE8;
        delay_addr = 16'h8002;
        delay_n    = 2;
        do_reset(16'h8000, 0);
        wait_read(16'h8002, ok);
        chk("abort_read_seen", ok, 1);
        pc_load       = 1'b1;
        pc_load_value = 16'hC000;
        @(negedge clk);
        pc_load = 1'b0;
        chk("abort_rd_drop", mem_rd, 0);
        chk("abort_pc", pc, 16'hC000);
        chk("abort_ready", instruction_ready, 0);
        chk("abort_reads", rd_count, 4);
        saw_ready = 1'b0;
        ok        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instruction_ready) saw_ready = 1'b1;
            if (mem_rd) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_restart_seen", ok, 1);
        chk("abort_no_ready", saw_ready, 0);
        chk("abort_restart_addr", mem_addr, 16'hC000);
        wait_ready(ok);
        chk("abort_new_ready", ok, 1);
        chk("abort_new_instr", instruction_out, 8'hE8);
        chk("abort_new_operand", operand_addr, 16'h0000);
        chk("abort_new_pc", pc, 16'hC001);
        delay_n = 0;

        // pc_load in WAIT: first without done, then together with done.
        mem[16'h8000] = 8'hA9;
        mem[16'h8001] = 8'h42;
        mem[16'h9000] = 8'hE8;
        do_reset(16'h8000, 0);
        wait_ready(ok);
        chk("wload_ready_seen", ok, 1);
        pc_load       = 1'b1;
        pc_load_value = 16'hA000;
        @(negedge clk);
        pc_load = 1'b0;
        chk("wload_pc", pc, 16'hA000);
        chk("wload_ready_kept", instruction_ready, 1);
        chk("wload_instr_kept", instruction_out, 8'hA9);
        chk("wload_operand_kept", operand_addr, 16'h0042);
        pc_load          = 1'b1;
        pc_load_value    = 16'h9000;
        instruction_done = 1'b1;
        @(negedge clk);
        pc_load          = 1'b0;
        instruction_done = 1'b0;
        chk("wdone_ready", instruction_ready, 0);
        chk("wdone_pc", pc, 16'h9000);
        chk("wdone_gap_rd", mem_rd, 0);
        @(negedge clk);
        chk("wdone_next", {mem_rd, mem_addr}, {1'b1, 16'h9000});

        // Asynchronous reset while an instruction is presented.
        wait_ready(ok);
        chk("rst_ready_seen", ok, 1);
        chk("rst_pre_instr", instruction_out, 8'hE8);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_wait");
        @(negedge clk);
        chk_reset_vals("rst_hold");
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
